// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the multi-cycle CPU controller: state encoding,
// opcode/funct values, ALU commands and datapath mux selects.
package cpu_defs;

  localparam int unsigned STATE_W   = 4;
  localparam int unsigned OP_W      = 6;
  localparam int unsigned FUNCT_W   = 6;
  localparam int unsigned SEL_W     = 2;
  localparam int unsigned ALU_CMD_W = 3;
  localparam int unsigned LINK_REG  = 31;

  typedef enum logic [STATE_W-1:0] {
    S_START    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_ALU   = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_WB_MEM   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JUMP_R   = 4'd12,
    S_HALT     = 4'd13
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [FUNCT_W-1:0] FN_JR  = 6'h08;
  localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2A;

  localparam int unsigned ALU_ADD = 0;
  localparam int unsigned ALU_SUB = 1;
  localparam int unsigned ALU_XOR = 2;
  localparam int unsigned ALU_SLT = 3;

  localparam logic [SEL_W-1:0] REG_DST_RT   = 2'd0;
  localparam logic [SEL_W-1:0] REG_DST_RD   = 2'd1;
  localparam logic [SEL_W-1:0] REG_DST_LINK = 2'd2;

  localparam logic [SEL_W-1:0] MTR_ALUOUT = 2'd0;
  localparam logic [SEL_W-1:0] MTR_MDR    = 2'd1;
  localparam logic [SEL_W-1:0] MTR_PC     = 2'd2;

  localparam logic SRC_A_PC = 1'b0;
  localparam logic SRC_A_DA = 1'b1;

  localparam logic [SEL_W-1:0] SRC_B_REG    = 2'd0;
  localparam logic [SEL_W-1:0] SRC_B_FOUR   = 2'd1;
  localparam logic [SEL_W-1:0] SRC_B_IMM    = 2'd2;
  localparam logic [SEL_W-1:0] SRC_B_IMM_SH = 2'd3;

  localparam logic [SEL_W-1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [SEL_W-1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [SEL_W-1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [SEL_W-1:0] PC_SRC_REG    = 2'd3;

  function automatic logic is_rtype(input logic [OP_W-1:0] op);
    return op == OP_RTYPE;
  endfunction

endpackage

// File: rtl/alu_cmd_decode.sv
// Combinational ALU command selection from the current state and the
// instruction held in IR; also flags whether an R-type funct is supported.
module alu_cmd_decode
  import cpu_defs::*;
#(
  parameter int unsigned CMD_W = ALU_CMD_W
) (
  input  state_t             state,
  input  logic [OP_W-1:0]    opcode,
  input  logic [FUNCT_W-1:0] funct,
  output logic [CMD_W-1:0]   alu_command,
  output logic               funct_ok
);

  always_comb begin
    funct_ok = 1'b0;
    case (funct)
      FN_ADD, FN_SUB, FN_SLT: funct_ok = 1'b1;
      default:                funct_ok = 1'b0;
    endcase
  end

  // ADD is the resting command; fetch/decode/address states rely on it.
  always_comb begin
    alu_command = CMD_W'(ALU_ADD);
    case (state)
      S_EXEC_R: begin
        case (funct)
          FN_SUB:  alu_command = CMD_W'(ALU_SUB);
          FN_SLT:  alu_command = CMD_W'(ALU_SLT);
          default: alu_command = CMD_W'(ALU_ADD);
        endcase
      end
      S_EXEC_I: begin
        if (opcode == OP_XORI) alu_command = CMD_W'(ALU_XOR);
      end
      S_BRANCH: alu_command = CMD_W'(ALU_SUB);
      default:  alu_command = CMD_W'(ALU_ADD);
    endcase
  end

endmodule

// File: rtl/multicycle_fsm.sv
// Multi-cycle CPU control FSM: sequences fetch, decode, execute, memory and
// writeback over the shared ALU, regfile and unified memory.
module multicycle_fsm
  import cpu_defs::*;
#(
  parameter int unsigned CMD_W = ALU_CMD_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    opcode,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic [SEL_W-1:0]   reg_dst,
  output logic [SEL_W-1:0]   mem_to_reg,
  output logic               alu_src_a,
  output logic [SEL_W-1:0]   alu_src_b,
  output logic [CMD_W-1:0]   alu_command,
  output logic [SEL_W-1:0]   pc_source,
  output logic               halted
);

  state_t state;
  state_t state_nxt;
  logic   funct_ok;
  logic   rtype;

  assign rtype = is_rtype(opcode);

  alu_cmd_decode #(
    .CMD_W(CMD_W)
  ) u_alu_cmd_decode (
    .state      (state),
    .opcode     (opcode),
    .funct      (funct),
    .alu_command(alu_command),
    .funct_ok   (funct_ok)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_START;
    else       state <= state_nxt;
  end

  // Next-state: memory states hold until mem_ready, HALT holds until reset.
  always_comb begin
    state_nxt = state;
    case (state)
      S_START:  state_nxt = S_FETCH;
      S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        if (rtype) begin
          state_nxt = (funct == FN_JR) ? S_JUMP_R : S_EXEC_R;
        end else begin
          case (opcode)
            OP_LW, OP_SW:     state_nxt = S_MEM_ADDR;
            OP_ADDI, OP_XORI: state_nxt = S_EXEC_I;
            OP_BEQ, OP_BNE:   state_nxt = S_BRANCH;
            OP_J, OP_JAL:     state_nxt = S_JUMP;
            default:          state_nxt = S_HALT;
          endcase
        end
      end
      S_EXEC_R:   state_nxt = funct_ok ? S_WB_ALU : S_HALT;
      S_EXEC_I:   state_nxt = S_WB_ALU;
      S_WB_ALU:   state_nxt = S_FETCH;
      S_MEM_ADDR: state_nxt = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) state_nxt = S_WB_MEM;
      S_MEM_WR:   if (mem_ready) state_nxt = S_FETCH;
      S_WB_MEM:   state_nxt = S_FETCH;
      S_BRANCH:   state_nxt = S_FETCH;
      S_JUMP:     state_nxt = S_FETCH;
      S_JUMP_R:   state_nxt = S_FETCH;
      S_HALT:     state_nxt = S_HALT;
      default:    state_nxt = S_START;
    endcase
  end

  // Outputs follow the state register; only the fetch strobes see mem_ready.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = REG_DST_RT;
    mem_to_reg = MTR_ALUOUT;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_REG;
    pc_source  = PC_SRC_ALU;
    halted     = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRC_B_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = SRC_B_IMM_SH;
      S_EXEC_R: alu_src_a = SRC_A_DA;
      S_EXEC_I: begin
        alu_src_a = SRC_A_DA;
        alu_src_b = SRC_B_IMM;
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        reg_dst   = rtype ? REG_DST_RD : REG_DST_RT;
      end
      S_MEM_ADDR: begin
        alu_src_a = SRC_A_DA;
        alu_src_b = SRC_B_IMM;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = MTR_MDR;
      end
      S_BRANCH: begin
        alu_src_a = SRC_A_DA;
        pc_source = PC_SRC_ALUOUT;
        pc_write  = (opcode == OP_BEQ) ? zero : ~zero;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PC_SRC_JUMP;
        if (opcode == OP_JAL) begin
          reg_write  = 1'b1;
          reg_dst    = REG_DST_LINK;
          mem_to_reg = MTR_PC;
        end
      end
      S_JUMP_R: begin
        pc_write  = 1'b1;
        pc_source = PC_SRC_REG;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule
